// File: rtl/ras_stack.sv
// Return address stack: circular buffer of link addresses pushed on calls, popped on returns,
// with pointer/count checkpoint and restore for misprediction recovery.

package config_pkg;
   localparam int unsigned VLEN = 32;
endpackage

module ras_stack #(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        flush_i,
   input  logic                        push_i,
   input  logic                        pop_i,
   input  logic [config_pkg::VLEN-1:0] data_i,
   input  logic                        restore_i,
   input  logic [PTR_W-1:0]            restore_ptr_i,
   input  logic [CNT_W-1:0]            restore_cnt_i,
   output logic [config_pkg::VLEN-1:0] data_o,
   output logic                        valid_o,
   output logic [PTR_W-1:0]            ptr_o,
   output logic [CNT_W-1:0]            cnt_o
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [config_pkg::VLEN-1:0] entries [DEPTH];
   logic [PTR_W-1:0]            ptr;
   logic [CNT_W-1:0]            cnt;
   logic [PTR_W-1:0]            ptr_inc;
   logic [PTR_W-1:0]            ptr_dec;
   logic                        not_empty;

   assign not_empty = (cnt != '0);
   assign ptr_inc   = ptr + PTR_W'(1);
   assign ptr_dec   = ptr - PTR_W'(1);

   assign valid_o = not_empty;
   assign data_o  = not_empty ? entries[ptr] : '0;
   assign ptr_o   = ptr;
   assign cnt_o   = cnt;

   // A simultaneous push and pop on a non-empty stack replaces the top in place;
   // on an empty stack it falls through to a plain push.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr <= '0;
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (flush_i) begin
         ptr <= '0;
         cnt <= '0;
      end else if (restore_i) begin
         ptr <= restore_ptr_i;
         cnt <= restore_cnt_i;
      end else if (push_i && pop_i && not_empty) begin
         entries[ptr] <= data_i;
      end else if (push_i) begin
         ptr              <= ptr_inc;
         entries[ptr_inc] <= data_i;
         if (cnt != CNT_FULL) begin
            cnt <= cnt + CNT_W'(1);
         end
      end else if (pop_i && not_empty) begin
         ptr <= ptr_dec;
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ras_stack.sv
// Directed self-checking bench for ras_stack (DEPTH=4): LIFO order, overflow, underflow,
// push+pop swap, checkpoint restore, flush priority and asynchronous reset.

module tb_ras_stack;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned VW    = config_pkg::VLEN;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          flush_i;
   logic          push_i;
   logic          pop_i;
   logic [VW-1:0] data_i;
   logic          restore_i;
   logic [1:0]    restore_ptr_i;
   logic [2:0]    restore_cnt_i;
   logic [VW-1:0] data_o;
   logic          valid_o;
   logic [1:0]    ptr_o;
   logic [2:0]    cnt_o;

   int errors = 0;
   int checks = 0;

   ras_stack #(.DEPTH(DEPTH)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .flush_i       (flush_i),
      .push_i        (push_i),
      .pop_i         (pop_i),
      .data_i        (data_i),
      .restore_i     (restore_i),
      .restore_ptr_i (restore_ptr_i),
      .restore_cnt_i (restore_cnt_i),
      .data_o        (data_o),
      .valid_o       (valid_o),
      .ptr_o         (ptr_o),
      .cnt_o         (cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      flush_i = 0; push_i = 0; pop_i = 0; restore_i = 0;
   endtask

   task automatic push(input logic [VW-1:0] d);
      idle(); push_i = 1; data_i = d; tick(); idle();
   endtask

   task automatic check_state(input string tag, input logic v, input logic [VW-1:0] d,
                              input logic [1:0] p, input logic [2:0] c);
      check({tag, ".valid"}, 64'(valid_o), 64'(v));
      check({tag, ".data"},  64'(data_o),  64'(d));
      check({tag, ".ptr"},   64'(ptr_o),   64'(p));
      check({tag, ".cnt"},   64'(cnt_o),   64'(c));
   endtask

   initial begin
      rst_ni = 0; data_i = '0; restore_ptr_i = '0; restore_cnt_i = '0;
      idle();
      #12;
      check_state("reset", 0, 0, 0, 0);
      rst_ni = 1;
      tick();

      // LIFO order over three calls
      push(32'h1000); push(32'h2000); push(32'h3000);
      check_state("push3", 1, 32'h3000, 3, 3);
      pop_i = 1;
      check("pop1.data", 64'(data_o), 64'h3000); tick();
      check("pop2.data", 64'(data_o), 64'h2000); tick();
      check("pop3.data", 64'(data_o), 64'h1000); tick();
      idle();
      check_state("popped", 0, 0, 0, 0);

      // Five pushes on a 4-deep stack overwrite the oldest
      push(32'hA); push(32'hB); push(32'hC); push(32'hD); push(32'hE);
      check_state("ovf", 1, 32'hE, 1, 4);
      pop_i = 1;
      check("ovf.pop1", 64'(data_o), 64'hE); tick();
      check("ovf.pop2", 64'(data_o), 64'hD); tick();
      check("ovf.pop3", 64'(data_o), 64'hC); tick();
      check("ovf.pop4", 64'(data_o), 64'hB); tick();
      idle();
      check_state("ovf.empty", 0, 0, 1, 0);

      // Underflow is ignored
      flush_i = 1; tick(); idle();
      pop_i = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_state("udf", 0, 0, 0, 0);
      end
      idle();

      // Push+pop swaps the top; on an empty stack it acts as a push
      push(32'h100);
      push_i = 1; pop_i = 1; data_i = 32'h200; tick(); idle();
      check_state("swap", 1, 32'h200, 1, 1);
      flush_i = 1; tick(); idle();
      push_i = 1; pop_i = 1; data_i = 32'h300; tick(); idle();
      check_state("swap.empty", 1, 32'h300, 1, 1);

      // Checkpoint restore, arranged so the checkpoint is ptr=1 cnt=2
      restore_i = 1; restore_ptr_i = 3; restore_cnt_i = 0; tick(); idle();
      check_state("rst.empty", 0, 0, 3, 0);
      push(32'h10); push(32'h20);
      check_state("ckpt", 1, 32'h20, 1, 2);
      push(32'h30);
      pop_i = 1; tick(); tick(); idle();
      check_state("prerestore", 1, 32'h10, 0, 1);
      restore_i = 1; restore_ptr_i = 1; restore_cnt_i = 2; tick(); idle();
      check_state("restore", 1, 32'h20, 1, 2);
      restore_i = 1; push_i = 1; data_i = 32'hDEAD; tick(); idle();
      check_state("restore.push", 1, 32'h20, 1, 2);

      // Flush wins over push and pop
      flush_i = 1; push_i = 1; pop_i = 1; data_i = 32'h77; tick(); idle();
      check_state("flush", 0, 0, 0, 0);

      // Asynchronous reset between clock edges
      push(32'h55);
      check_state("prereset", 1, 32'h55, 1, 1);
      #2;
      rst_ni = 0;
      #1;
      check_state("async", 0, 0, 0, 0);
      tick();
      rst_ni = 1;
      tick();
      check_state("postreset", 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Return address stack. Consumes the call/return classification produced by the frontend instruction predecoder.
- A call (RVI or RVC) pushes the link address. A return pops and supplies the predicted target to the frontend PC select.
- Circular buffer of DEPTH entries. On overflow the oldest entry is overwritten.
- Pointer/count snapshot and restore ports support misprediction recovery from the backend.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridable).
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  empty the stack (pipeline flush / fence.i).
- push_i  in  1  call seen (rvi_call or rvc_call) on a valid fetch.
- pop_i  in  1  return seen (rvi_return or rvc_return) on a valid fetch.
- data_i  in  config_pkg::VLEN  link address to push (call PC + 4, or + 2 for RVC).
- restore_i  in  1  restore pointer/count from a checkpoint.
- restore_ptr_i  in  PTR_W  checkpointed top-of-stack pointer.
- restore_cnt_i  in  CNT_W  checkpointed occupancy; must be <= DEPTH.
- data_o  out  config_pkg::VLEN  predicted return target (current TOS).
- valid_o  out  1  stack non-empty; data_o usable.
- ptr_o  out  PTR_W  current TOS pointer, for checkpointing.
- cnt_o  out  CNT_W  current occupancy, for checkpointing.

Behaviour:
- Reset (rst_ni low, async): all entries 0, ptr 0, cnt 0. Therefore data_o 0, valid_o 0, ptr_o 0, cnt_o 0.
- Read path is combinational:
  - valid_o = (cnt != 0).
  - data_o = valid_o ? entry[ptr] : 0.
  - ptr_o = ptr; cnt_o = cnt.
- A pop consumes the data_o value presented in the same cycle.
- All state updates occur on the rising clk_i edge. Priority: flush_i > restore_i > push/pop.
- flush_i: ptr 0, cnt 0. Entry contents are kept but invisible, because data_o is forced to 0.
- restore_i (no flush): ptr = restore_ptr_i, cnt = restore_cnt_i. Entries are not modified. push_i/pop_i that cycle are ignored.
- Push only:
  - ptr = ptr+1 mod DEPTH; entry[new ptr] = data_i.
  - cnt = min(cnt+1, DEPTH).
  - When full, the oldest entry is silently overwritten.
- Pop only:
  - If cnt>0: ptr = ptr-1 mod DEPTH, cnt = cnt-1.
  - If cnt==0: no state change (underflow ignored).
- Push and pop together (jalr with rd and rs1 both link registers, i.e. a coroutine swap):
  - If cnt>0: entry[ptr] = data_i; ptr and cnt unchanged.
  - If cnt==0: behave as push only (cnt becomes 1).
- Pointer arithmetic wraps modulo DEPTH. cnt saturates at DEPTH and never exceeds it.
- Update latency: a push is visible on data_o the cycle after it. Back-to-back push/pop every cycle must be supported.
- No X propagation: data_o is 0 whenever valid_o is 0.

Test Plan:
- Reset, then push 0x1000, 0x2000, 0x3000 on consecutive cycles -> cnt_o 3, data_o 0x3000. Pop on three consecutive cycles -> data_o shows 0x3000, 0x2000, 0x1000 in the pop cycles, then valid_o 0 and data_o 0.
- DEPTH=4, push A..E (five pushes) -> cnt_o 4, pops return E, D, C, B, then valid_o 0. A was overwritten.
- Empty stack, pop_i held 3 cycles -> cnt_o stays 0, ptr_o stays 0, valid_o 0.
- Push 0x100, then push+pop with data_i 0x200 -> cnt_o 1, data_o 0x200. Push+pop on empty stack with 0x300 -> cnt_o 1, data_o 0x300.
- Push 0x10 and 0x20, record ptr_o/cnt_o (1/2). Push 0x30, pop twice, then restore_i with 1/2 -> data_o 0x20, cnt_o 2. Drive restore_i and push_i together -> the push is ignored.
- Stack holding 2 entries with flush_i, push_i and pop_i all asserted -> cnt_o 0, ptr_o 0, valid_o 0. Assert rst_ni low mid-sequence, asynchronously between clock edges -> all outputs 0 immediately.
